// File: rtl/spi_ram_bridge_pkg.sv
// Shared constants for the SPI-to-RAM bridge: command encodings, FSM state
// encodings and the frame width helper.
package spi_ram_pkg;

    // Command field (first two bits of every frame)
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // FSM state encodings
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RECV    = 3'd1;
    localparam state_t ST_EXEC    = 3'd2;
    localparam state_t ST_TX      = 3'd3;
    localparam state_t ST_WAIT_SS = 3'd4;

    // Frame = 2 command bits + a payload wide enough for an address or a word
    function automatic int frame_w(input int aw, input int dw);
        return 2 + ((aw > dw) ? aw : dw);
    endfunction

endpackage

// File: rtl/spi_ram_bridge_mem.sv
// Word-addressed RAM for the bridge: synchronous write, registered read with
// one cycle of latency. The array is deliberately not reset.
module spi_ram_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write port: one word per enabled edge
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: address sampled every edge, data available the next cycle
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_bridge.sv
// SPI slave that accepts command frames on MOSI, executes them against an
// internal RAM and returns read words on MISO. clk is the SPI serial clock.
module spi_ram_bridge
    import spi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int AUTO_INC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic cmd_err
);

    localparam int FRAME_W = frame_w(ADDR_WIDTH, DATA_WIDTH);
    localparam int PAY_W   = FRAME_W - 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TXC_W   = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0]      BIT_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [TXC_W-1:0]      TX_LAST   = TXC_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    // Registered state
    state_t                r_state;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [FRAME_W-1:0]    r_rx;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [TXC_W-1:0]      r_tx_cnt;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_valid;
    logic                  r_miso;
    logic                  r_busy;
    logic                  r_cmd_err;

    // Decoded frame and helpers
    state_t                w_next_state;
    logic [1:0]            w_cmd;
    logic [PAY_W-1:0]      w_payload;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_addr_ok;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Pointer post-increment that wraps at the last valid word, not at 2**AW
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        if (p == LAST_ADDR) begin
            return '0;
        end else begin
            return p + ADDR_WIDTH'(1);
        end
    endfunction

    assign w_cmd     = r_rx[FRAME_W-1 -: 2];
    assign w_payload = r_rx[PAY_W-1:0];
    assign w_addr    = w_payload[ADDR_WIDTH-1:0];
    assign w_data    = w_payload[DATA_WIDTH-1:0];
    assign w_addr_ok = ({1'b0, w_addr} < DEPTH_W);

    // The write lands on the EXEC edge; reset on that edge cancels it
    assign w_mem_we  = (r_state == ST_EXEC) && (w_cmd == CMD_WR_DATA) && !rst;

    // The read port always tracks rd_addr, so at EXEC it already holds the word
    spi_ram_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_addr),
        .i_wdata (w_data),
        .i_raddr (r_rd_addr),
        .o_rdata (w_rdata)
    );

    // Next-state decode; SS_n high aborts RECV/TX and ends EXEC/WAIT_SS
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!SS_n) begin
                    w_next_state = ST_RECV;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (SS_n) begin
                    w_next_state = ST_IDLE;
                end else if (r_bit_cnt == BIT_LAST) begin
                    w_next_state = ST_EXEC;
                end else begin
                    w_next_state = ST_RECV;
                end
            end
            ST_EXEC: begin
                if (SS_n) begin
                    w_next_state = ST_IDLE;
                end else if ((w_cmd == CMD_RD_DATA) && r_rd_valid) begin
                    w_next_state = ST_TX;
                end else begin
                    w_next_state = ST_WAIT_SS;
                end
            end
            ST_TX: begin
                if (SS_n) begin
                    w_next_state = ST_IDLE;
                end else if (r_tx_cnt == TX_LAST) begin
                    w_next_state = ST_WAIT_SS;
                end else begin
                    w_next_state = ST_TX;
                end
            end
            ST_WAIT_SS: begin
                if (SS_n) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT_SS;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM datapath: shifters, pointers, command execution and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_rx       <= '0;
            r_tx       <= '0;
            r_tx_cnt   <= '0;
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_rd_valid <= 1'b0;
            r_miso     <= 1'b0;
            r_busy     <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_busy    <= (w_next_state != ST_IDLE);
            r_cmd_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= '0;
                    r_miso    <= 1'b0;
                end
                ST_RECV: begin
                    // A partial frame only touches rx/bit_cnt, which IDLE discards
                    r_rx      <= {r_rx[FRAME_W-2:0], MOSI};
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    r_miso    <= 1'b0;
                end
                ST_EXEC: begin
                    r_miso <= 1'b0;
                    case (w_cmd)
                        CMD_WR_ADDR: begin
                            if (w_addr_ok) begin
                                r_wr_addr <= w_addr;
                            end else begin
                                r_cmd_err <= 1'b1;
                            end
                        end
                        CMD_WR_DATA: begin
                            if (AUTO_INC != 0) begin
                                r_wr_addr <= ptr_inc(r_wr_addr);
                            end else begin
                                r_wr_addr <= r_wr_addr;
                            end
                        end
                        CMD_RD_ADDR: begin
                            if (w_addr_ok) begin
                                r_rd_addr  <= w_addr;
                                r_rd_valid <= 1'b1;
                            end else begin
                                r_cmd_err <= 1'b1;
                            end
                        end
                        CMD_RD_DATA: begin
                            if (r_rd_valid) begin
                                r_tx     <= w_rdata;
                                r_tx_cnt <= '0;
                                if (AUTO_INC != 0) begin
                                    r_rd_addr <= ptr_inc(r_rd_addr);
                                end else begin
                                    r_rd_addr <= r_rd_addr;
                                end
                            end else begin
                                r_cmd_err <= 1'b1;
                            end
                        end
                        default: begin
                            r_cmd_err <= 1'b1;
                        end
                    endcase
                end
                ST_TX: begin
                    if (SS_n) begin
                        r_miso <= 1'b0;
                    end else begin
                        r_miso   <= r_tx[DATA_WIDTH-1];
                        r_tx     <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                        r_tx_cnt <= r_tx_cnt + TXC_W'(1);
                    end
                end
                ST_WAIT_SS: begin
                    r_miso <= 1'b0;
                end
                default: begin
                    r_miso <= 1'b0;
                end
            endcase
        end
    end

    assign MISO    = r_miso;
    assign busy    = r_busy;
    assign cmd_err = r_cmd_err;

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Scoreboard bench for spi_ram_bridge: a default instance (8/8/256) and a wide
// instance (10/16/600). Frames push their expected outcome into a queue; the
// monitor watches busy/MISO/cmd_err and checks each frame as it completes.
module tb_spi_ram_bridge;

    localparam int FW_A = 10;
    localparam int DW_A = 8;
    localparam int FW_B = 18;
    localparam int DW_B = 16;

    typedef struct {
        int          nerr;
        logic [15:0] word;
        int          len;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ss_a, mosi_a, miso_a, busy_a, err_a;
    logic ss_b, mosi_b, miso_b, busy_b, err_b;

    logic act;
    logic mon_en;
    logic m_busy, m_err, m_miso;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    spi_ram_bridge u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .SS_n    (ss_a),
        .MOSI    (mosi_a),
        .MISO    (miso_a),
        .busy    (busy_a),
        .cmd_err (err_a)
    );

    spi_ram_bridge #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (16),
        .MEM_DEPTH  (600),
        .AUTO_INC   (1)
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .SS_n    (ss_b),
        .MOSI    (mosi_b),
        .MISO    (miso_b),
        .busy    (busy_b),
        .cmd_err (err_b)
    );

    always #5 clk = ~clk;

    assign m_busy = act ? busy_b : busy_a;
    assign m_err  = act ? err_b  : err_a;
    assign m_miso = act ? miso_b : miso_a;

    task automatic check(input string name, input longint got, input longint expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic set_ss(input bit wide, input logic v);
        if (wide) ss_b = v;
        else      ss_a = v;
    endtask

    task automatic set_mosi(input bit wide, input logic v);
        if (wide) mosi_b = v;
        else      mosi_a = v;
    endtask

    // One frame. stop_after>=0: raise SS_n after that many MOSI bits.
    // rst_tx>=0: pulse rst after that many MISO bits have been shifted.
    task automatic run_frame(input bit wide, input logic [1:0] cmd, input logic [15:0] pay,
                             input int stop_after, input int rst_tx,
                             input int exp_err, input logic [15:0] exp_word);
        int   fw, dw;
        bit   aborted;
        logic b;
        exp_t e;
        fw = wide ? FW_B : FW_A;
        dw = wide ? DW_B : DW_A;
        aborted = 1'b0;
        e.nerr = exp_err;
        e.word = exp_word;
        if (stop_after >= 0)  e.len = stop_after + 1;
        else if (rst_tx >= 0) e.len = fw + 2 + rst_tx;
        else                  e.len = fw + 3 + dw;
        exp_q.push_back(e);
        act = wide;
        @(negedge clk);
        set_ss(wide, 1'b0);
        for (int i = 0; i < fw; i++) begin
            @(negedge clk);
            if (i == stop_after) begin
                set_ss(wide, 1'b1);
                aborted = 1'b1;
                break;
            end
            b = (i < 2) ? cmd[1-i] : pay[fw-1-i];
            set_mosi(wide, b);
        end
        if (!aborted) begin
            @(negedge clk);
            set_mosi(wide, 1'b0);
            for (int k = 0; k <= dw; k++) begin
                @(negedge clk);
                if (k == rst_tx) begin
                    rst = 1'b1;
                    set_ss(wide, 1'b1);
                    @(negedge clk);
                    rst = 1'b0;
                    break;
                end
            end
            @(negedge clk);
            set_ss(wide, 1'b1);
        end
        set_mosi(wide, 1'b0);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Monitor: from busy rising to busy falling, count cmd_err pulses,
    // assemble the MISO word and compare with the scoreboard head.
    initial begin : monitor
        logic        prev_busy;
        int          j, fw, dw, nerr, stray;
        logic [15:0] word;
        exp_t        e;
        prev_busy = 1'b0;
        wait (mon_en === 1'b1);
        forever begin
            @(negedge clk);
            if (m_busy === 1'b1 && prev_busy == 1'b0) begin
                fw = act ? FW_B : FW_A;
                dw = act ? DW_B : DW_A;
                j = 0; nerr = 0; stray = 0; word = '0;
                do begin
                    if (j > 0) @(negedge clk);
                    if (m_err === 1'b1) nerr++;
                    if (j >= fw + 2 && j < fw + 2 + dw) word[dw-1-(j-fw-2)] = m_miso;
                    else if (m_miso !== 1'b0) stray++;
                    j++;
                end while (m_busy === 1'b1 && j < 200);
                if (j >= 200) begin
                    check("frame_timeout", j, 0);
                end else if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_err_pulses", nerr, e.nerr);
                    check("miso_word", word, e.word);
                    check("busy_len", j - 1, e.len);
                    check("miso_idle_zero", stray, 0);
                end
            end
            prev_busy = m_busy;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst = 1'b1;
        ss_a = 1'b1; mosi_a = 1'b0;
        ss_b = 1'b1; mosi_b = 1'b0;
        act = 1'b0;
        mon_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_miso_a", miso_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_err_a",  err_a,  0);
        check("rst_miso_b", miso_b, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_err_b",  err_b,  0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // RD_DATA with no read address -> error, no data
        run_frame(0, 2'b11, 16'h0000, -1, -1, 1, 16'h0000);

        // Basic write / read-back
        run_frame(0, 2'b00, 16'h0010, -1, -1, 0, 16'h0000);
        run_frame(0, 2'b01, 16'h00A5, -1, -1, 0, 16'h0000);
        run_frame(0, 2'b10, 16'h0010, -1, -1, 0, 16'h0000);
        run_frame(0, 2'b11, 16'h0000, -1, -1, 0, 16'h00A5);

        // Burst across the 0xFF -> 0x00 wrap
        run_frame(0, 2'b00, 16'h00FE, -1, -1, 0, 16'h0000);
        run_frame(0, 2'b01, 16'h0011, -1, -1, 0, 16'h0000);
        run_frame(0, 2'b01, 16'h0022, -1, -1, 0, 16'h0000);
        run_frame(0, 2'b01, 16'h0033, -1, -1, 0, 16'h0000);
        run_frame(0, 2'b10, 16'h00FE, -1, -1, 0, 16'h0000);
        run_frame(0, 2'b11, 16'h0000, -1, -1, 0, 16'h0011);
        run_frame(0, 2'b11, 16'h0000, -1, -1, 0, 16'h0022);
        run_frame(0, 2'b11, 16'h0000, -1, -1, 0, 16'h0033);

        // Aborted frame after 5 bits; wr_addr must still be 0x01
        run_frame(0, 2'b01, 16'h0077,  5, -1, 0, 16'h0000);
        run_frame(0, 2'b01, 16'h005C, -1, -1, 0, 16'h0000);
        run_frame(0, 2'b10, 16'h0001, -1, -1, 0, 16'h0000);
        run_frame(0, 2'b11, 16'h0000, -1, -1, 0, 16'h005C);
        run_frame(0, 2'b10, 16'h0010, -1, -1, 0, 16'h0000);
        run_frame(0, 2'b11, 16'h0000, -1, -1, 0, 16'h00A5);

        // Reset after 3 of 8 MISO bits of 0xA5 -> 1,0,1 then zeros
        run_frame(0, 2'b10, 16'h0010, -1, -1, 0, 16'h0000);
        run_frame(0, 2'b11, 16'h0000, -1,  3, 0, 16'h00A0);
        run_frame(0, 2'b11, 16'h0000, -1, -1, 1, 16'h0000);

        // Wide instance: range check at 600, wrap 599 -> 0, 16-bit read-back
        run_frame(1, 2'b10, 16'd599, -1, -1, 0, 16'h0000);
        run_frame(1, 2'b10, 16'd600, -1, -1, 1, 16'h0000);
        run_frame(1, 2'b00, 16'd600, -1, -1, 1, 16'h0000);
        run_frame(1, 2'b00, 16'd599, -1, -1, 0, 16'h0000);
        run_frame(1, 2'b01, 16'hBEEF, -1, -1, 0, 16'h0000);
        run_frame(1, 2'b01, 16'h1234, -1, -1, 0, 16'h0000);
        run_frame(1, 2'b10, 16'd599, -1, -1, 0, 16'h0000);
        run_frame(1, 2'b10, 16'd600, -1, -1, 1, 16'h0000);
        run_frame(1, 2'b11, 16'h0000, -1, -1, 0, 16'hBEEF);
        run_frame(1, 2'b11, 16'h0000, -1, -1, 0, 16'h1234);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
